mem_arbiter_n: RTL and testbench
================================

# mem_arbiter_n

Parametrised N-port arbiter placed between the cache hierarchy (I-cache, D-cache, optional prefetcher or victim buffer) and the single physical-memory line port. It:
- grants one requester at a time under fixed-priority or round-robin policy;
- captures the granted request into registers, so pmem-side signals stay stable for the whole transaction;
- routes the response back to the owning port only.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesting ports; legal 2..8; port 0 is highest priority in fixed mode.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- GRANT_W, $clog2(NUM_PORTS), width of grant index; derived, not overridden.

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- port_address  in  NUM_PORTS x addr_t  per-port line address.
- port_wdata  in  NUM_PORTS x line_t  per-port write line.
- port_read  in  NUM_PORTS  per-port read request.
- port_write  in  NUM_PORTS  per-port write request.
- port_rdata  out  NUM_PORTS x line_t  read line; every entry carries pmem_rdata.
- port_resp  out  NUM_PORTS  one-hot completion pulse to the owner.
- pmem_address  out  addr_t  registered address to memory.
- pmem_wdata  out  line_t  registered write line.
- pmem_read  out  1  registered read strobe.
- pmem_write  out  1  registered write strobe.
- pmem_rdata  in  line_t  memory read line.
- pmem_resp  in  1  memory completion, one cycle.
- busy  out  1  high while a transaction is outstanding.
- grant_id  out  GRANT_W  index of current or last owner.

## Operation
- Per-port request: req[i] = port_read[i] | port_write[i].
- If a port asserts both read and write, the write wins.
- State machine:
  - IDLE: if any req, select winner g. Latch port_address[g], port_wdata[g] and the rw kind into registers. Set grant_id = g. Go to BUSY.
  - BUSY: pmem_read/pmem_write follow the latched kind. When pmem_resp = 1, pulse port_resp[g] combinationally and go to DONE.
  - DONE: all pmem strobes low for one turnaround cycle. Update the RR pointer. Then arbitrate exactly as in IDLE: go to BUSY if any req, otherwise to IDLE.
- Fixed priority: lowest index with req wins.
- Round-robin:
  - Search starts at ptr. Index wraps from NUM_PORTS-1 to 0.
  - After each completion, ptr = (g+1) mod NUM_PORTS.
- Requests sampled in BUSY are ignored; there is no queueing. Requesters must hold request and operands until their port_resp.
- If a requester drops its request mid-BUSY, the transaction still completes and port_resp[g] still pulses.
- port_resp is never asserted outside BUSY, and never for a non-owner.
- Reset, asynchronous at any time including mid-BUSY:
  - state IDLE, ptr 0, grant_id 0, busy 0;
  - pmem_read, pmem_write, pmem_address and pmem_wdata all 0;
  - port_resp 0.
  - The in-flight transaction is abandoned.

## Timing
- Request visible at edge k (IDLE) → pmem strobe high from cycle k+1. Grant latency is 1 cycle.
- pmem_resp in cycle m → port_resp[g] in cycle m (0 added latency). The state is DONE in cycle m+1, and the earliest next pmem strobe is m+2.
- pmem_address and pmem_wdata are constant for the whole of BUSY.
- busy = (state == BUSY).
- Back-to-back requests from the same port: each transaction costs pmem latency + 2 cycles.
- Simultaneous requests from all ports in RR mode: every port is served within NUM_PORTS transactions.

## Structure
- Shared package (adaptor_types), containing:
  - addr_t and line_t (already defined there);
  - new typedef arb_state_t {IDLE, BUSY, DONE};
  - constant ARB_MAX_PORTS = 8.
- One sub-module, arb_pick: combinational priority encoder taking a request vector, a start pointer and the mode, and returning the winner index and a valid flag.
- Everything else stays in mem_arbiter_n.

## Test plan
- Reset: rst low mid-BUSY with pmem_read = 1 → all outputs go to 0 without waiting for a clock edge. After release, idle with no strobes.
- Fixed mode, NUM_PORTS = 2:
  - Stimulus: port 0 read of 0x0000_1000 and port 1 write of 0x0000_2000 requested in the same cycle.
  - Response: port 0 served first (pmem_read, address 0x1000), port_resp[0] only. After the DONE cycle, the port 1 write runs with pmem_wdata = port_wdata[1].
- RR mode, NUM_PORTS = 4, all ports requesting continuously → grant order 0,1,2,3,0. No port_resp to a non-owner.
- Operand stability: port 0 changes port_address from 0x100 to 0x200 during BUSY → pmem_address stays 0x100 until pmem_resp.
- Withdrawn request: port 1 drops its read mid-BUSY → the transaction still completes and port_resp[1] pulses once.
- Read and write asserted together on port 2 → pmem_write = 1 and pmem_read = 0 for that transaction.

Source files
------------

// File: rtl/adaptor_types.sv
// Shared types for the cache-to-pmem adaptor path.
// Address/line widths and the arbiter state encoding.
package adaptor_types;

  localparam int ADDR_W        = 32;
  localparam int LINE_W        = 256;
  localparam int ARB_MAX_PORTS = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_n_pick.sv
// Combinational winner select for mem_arbiter_n.
// Fixed mode searches from 0, round-robin from ptr with wrap.
module arb_pick #(
  parameter int NUM_PORTS = 2,
  parameter int GRANT_W   = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GRANT_W-1:0]   ptr,
  input  logic                 rr_mode,
  output logic [GRANT_W-1:0]   idx,
  output logic                 valid
);

  always_comb begin
    int base;
    int j;
    idx   = '0;
    valid = 1'b0;
    base  = rr_mode ? int'(ptr) : 0;
    j     = 0;
    // Walk from farthest to nearest so the closest hit wins.
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      j = base + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (req[j[GRANT_W-1:0]]) begin
        idx   = j[GRANT_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-port arbiter in front of the single pmem line port.
// Grants one requester, latches its operands, returns resp to owner.
module mem_arbiter_n
  import adaptor_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter bit RR_MODE   = 1'b0,
  parameter int GRANT_W   = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] port_address,
  input  logic [NUM_PORTS-1:0][LINE_W-1:0] port_wdata,
  input  logic [NUM_PORTS-1:0]             port_read,
  input  logic [NUM_PORTS-1:0]             port_write,
  output logic [NUM_PORTS-1:0][LINE_W-1:0] port_rdata,
  output logic [NUM_PORTS-1:0]             port_resp,
  output logic [ADDR_W-1:0]                pmem_address,
  output logic [LINE_W-1:0]                pmem_wdata,
  output logic                             pmem_read,
  output logic                             pmem_write,
  input  logic [LINE_W-1:0]                pmem_rdata,
  input  logic                             pmem_resp,
  output logic                             busy,
  output logic [GRANT_W-1:0]               grant_id
);

  arb_state_t           state;
  logic [GRANT_W-1:0]   ptr;
  logic [GRANT_W-1:0]   nxt_ptr;
  logic [NUM_PORTS-1:0] req;
  logic [GRANT_W-1:0]   pick_idx;
  logic                 pick_valid;

  assign req = port_read | port_write;

  arb_pick #(
    .NUM_PORTS (NUM_PORTS),
    .GRANT_W   (GRANT_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .rr_mode (RR_MODE),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  assign nxt_ptr = (grant_id == GRANT_W'(NUM_PORTS-1))
                 ? '0 : grant_id + 1'b1;

  assign busy       = (state == BUSY);
  assign port_rdata = {NUM_PORTS{pmem_rdata}};

  always_comb begin
    port_resp = '0;
    if (state == BUSY && pmem_resp) port_resp[grant_id] = 1'b1;
  end

  // Pointer advances at completion so DONE already arbitrates from it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      grant_id     <= '0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (pick_valid) begin
            state        <= BUSY;
            grant_id     <= pick_idx;
            pmem_address <= port_address[pick_idx];
            pmem_wdata   <= port_wdata[pick_idx];
            pmem_write   <= port_write[pick_idx];
            pmem_read    <= ~port_write[pick_idx];
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            state      <= DONE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            ptr        <= nxt_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench: fixed 2-port and round-robin 4-port instances.
// Every expected value below is hand-derived from the timing rules.
module tb_mem_arbiter_n;
  import adaptor_types::*;

  localparam line_t LINE_A = {8{32'hA5A5_0001}};
  localparam line_t LINE_B = {8{32'h5A5A_0002}};
  localparam line_t LINE_C = {8{32'hC3C3_0003}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][ADDR_W-1:0] f_addr;
  logic [1:0][LINE_W-1:0] f_wdata, f_rdata;
  logic [1:0]             f_read, f_write, f_resp;
  logic [ADDR_W-1:0]      f_paddr;
  logic [LINE_W-1:0]      f_pwdata, f_prdata;
  logic                   f_pread, f_pwrite, f_presp, f_busy;
  logic [0:0]             f_gid;

  logic [3:0][ADDR_W-1:0] r_addr;
  logic [3:0][LINE_W-1:0] r_wdata, r_rdata;
  logic [3:0]             r_read, r_write, r_resp;
  logic [ADDR_W-1:0]      r_paddr;
  logic [LINE_W-1:0]      r_pwdata, r_prdata;
  logic                   r_pread, r_pwrite, r_presp, r_busy;
  logic [1:0]             r_gid;

  mem_arbiter_n #(.NUM_PORTS(2), .RR_MODE(1'b0)) u_fix (
    .clk(clk), .rst(rst),
    .port_address(f_addr), .port_wdata(f_wdata),
    .port_read(f_read), .port_write(f_write),
    .port_rdata(f_rdata), .port_resp(f_resp),
    .pmem_address(f_paddr), .pmem_wdata(f_pwdata),
    .pmem_read(f_pread), .pmem_write(f_pwrite),
    .pmem_rdata(f_prdata), .pmem_resp(f_presp),
    .busy(f_busy), .grant_id(f_gid)
  );

  mem_arbiter_n #(.NUM_PORTS(4), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .port_address(r_addr), .port_wdata(r_wdata),
    .port_read(r_read), .port_write(r_write),
    .port_rdata(r_rdata), .port_resp(r_resp),
    .pmem_address(r_paddr), .pmem_wdata(r_pwdata),
    .pmem_read(r_pread), .pmem_write(r_pwrite),
    .pmem_rdata(r_prdata), .pmem_resp(r_presp),
    .busy(r_busy), .grant_id(r_gid)
  );

  int vectors = 0;
  int errs    = 0;
  int seq [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag,
                     input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    f_addr = '0; f_wdata = '0; f_read = '0; f_write = '0;
    f_prdata = '0; f_presp = 1'b0;
    r_addr = '0; r_wdata = '0; r_read = '0; r_write = '0;
    r_prdata = '0; r_presp = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", {f_busy, r_busy}, 2'b00);
    chk("rst_strobes", {f_pread, f_pwrite, r_pread, r_pwrite}, 4'b0);
    chk("rst_gid", {f_gid, r_gid}, 3'b0);
    chk("rst_paddr", f_paddr, 32'h0);
    rst = 1'b1;

    // Fixed priority: port 0 read vs port 1 write in the same cycle
    @(negedge clk);
    f_read[0] = 1'b1; f_addr[0] = 32'h0000_1000;
    f_write[1] = 1'b1; f_addr[1] = 32'h0000_2000;
    f_wdata[1] = LINE_A;
    @(negedge clk);
    chk("fix_rd_strobe", {f_pread, f_pwrite}, 2'b10);
    chk("fix_rd_addr", f_paddr, 32'h0000_1000);
    chk("fix_rd_gid", f_gid, 1'b0);
    chk("fix_rd_busy", f_busy, 1'b1);
    f_presp = 1'b1; #1;
    chk("fix_rd_resp", f_resp, 2'b01);
    f_read[0] = 1'b0;
    @(negedge clk);
    f_presp = 1'b0;
    chk("fix_done", {f_busy, f_pread, f_pwrite, f_resp}, 5'b0);
    @(negedge clk);
    chk("fix_wr_strobe", {f_pread, f_pwrite}, 2'b01);
    chk("fix_wr_addr", f_paddr, 32'h0000_2000);
    chk("fix_wr_wdata", f_pwdata, LINE_A);
    chk("fix_wr_gid", f_gid, 1'b1);
    f_presp = 1'b1; #1;
    chk("fix_wr_resp", f_resp, 2'b10);
    f_write[1] = 1'b0;
    @(negedge clk);
    f_presp = 1'b0;
    @(negedge clk);
    chk("fix_idle", {f_busy, f_pread, f_pwrite}, 3'b0);

    // Round-robin: all four ports request continuously
    for (int i = 0; i < 4; i++) begin
      r_read[i] = 1'b1;
      r_addr[i] = 32'h1000 * (i + 1);
    end
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("rr_gid", r_gid, seq[t]);
      chk("rr_addr", r_paddr, 32'h1000 * (seq[t] + 1));
      chk("rr_strobe", {r_pread, r_pwrite}, 2'b10);
      r_presp = 1'b1; #1;
      chk("rr_resp", r_resp, 4'b1 << seq[t]);
      @(negedge clk);
      r_presp = 1'b0;
      chk("rr_done", {r_busy, r_pread, r_resp}, 6'b0);
      if (t == 4) r_read = '0;
    end

    // Operand stability: address changes while BUSY
    @(negedge clk);
    r_read[0] = 1'b1; r_addr[0] = 32'h100;
    @(negedge clk);
    chk("stab_gid", r_gid, 2'd0);
    chk("stab_addr0", r_paddr, 32'h100);
    r_addr[0] = 32'h200;
    @(negedge clk);
    chk("stab_addr1", r_paddr, 32'h100);
    @(negedge clk);
    chk("stab_addr2", r_paddr, 32'h100);
    r_presp = 1'b1; #1;
    chk("stab_resp", r_resp, 4'b0001);
    r_read[0] = 1'b0;
    @(negedge clk);
    r_presp = 1'b0;
    chk("stab_done", r_busy, 1'b0);

    // Withdrawn request: port 1 drops read mid-BUSY
    @(negedge clk);
    r_read[1] = 1'b1; r_addr[1] = 32'h400;
    @(negedge clk);
    chk("wd_gid", r_gid, 2'd1);
    chk("wd_strobe", r_pread, 1'b1);
    r_read[1] = 1'b0;
    @(negedge clk);
    chk("wd_hold", {r_busy, r_pread}, 2'b11);
    chk("wd_addr", r_paddr, 32'h400);
    r_presp = 1'b1; #1;
    chk("wd_resp", r_resp, 4'b0010);
    @(negedge clk);
    r_presp = 1'b0;
    chk("wd_done", {r_busy, r_resp}, 5'b0);
    @(negedge clk);
    chk("wd_idle", {r_busy, r_pread, r_resp}, 6'b0);

    // Read+write together on port 2: write wins
    r_read[2] = 1'b1; r_write[2] = 1'b1;
    r_addr[2] = 32'h500; r_wdata[2] = LINE_B;
    @(negedge clk);
    chk("rw_strobe", {r_pwrite, r_pread}, 2'b10);
    chk("rw_gid", r_gid, 2'd2);
    chk("rw_wdata", r_pwdata, LINE_B);
    chk("rw_addr", r_paddr, 32'h500);
    r_prdata = LINE_C; r_presp = 1'b1; #1;
    chk("rw_resp", r_resp, 4'b0100);
    chk("rw_rdata", r_rdata[2], LINE_C);
    r_read[2] = 1'b0; r_write[2] = 1'b0;
    @(negedge clk);
    r_presp = 1'b0;
    @(negedge clk);
    chk("rw_last_gid", {r_busy, r_gid}, 3'b010);

    // Asynchronous reset mid-BUSY
    f_write[1] = 1'b1; f_addr[1] = 32'h3000; f_wdata[1] = LINE_C;
    @(negedge clk);
    chk("ar_pre", {f_busy, f_pwrite, f_gid}, 3'b111);
    chk("ar_pre_addr", f_paddr, 32'h3000);
    #2;
    f_presp = 1'b1;
    rst = 1'b0;
    #1;
    chk("ar_strobes", {f_pread, f_pwrite, f_busy}, 3'b0);
    chk("ar_addr", f_paddr, 32'h0);
    chk("ar_wdata", f_pwdata, '0);
    chk("ar_gid", {f_gid, r_gid}, 3'b0);
    chk("ar_resp", f_resp, 2'b00);
    f_presp = 1'b0; f_write = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("ar_idle", {f_busy, f_pread, f_pwrite, f_resp}, 5'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
